// File: rtl/pad_alsaqr_pkg.sv
// Shared types and constants for the pad_alsaqr bank controller:
// per-pad config byte layout, its reset value and the power sequencer states.
package pad_alsaqr_pkg;

  typedef struct packed {
    logic       rsvd;
    logic       force_hiz;
    logic       filt_en;
    logic       smt;
    logic       slw;
    logic       puen;
    logic [1:0] drv;
  } pad_cfg_t;

  localparam pad_cfg_t   PAD_CFG_RST   = 8'h55;
  localparam logic [7:0] PAD_CFG_WMASK = 8'h7f;

  typedef enum logic [2:0] {
    PWR_OFF,
    PWR_IO_UP,
    PWR_CORE_UP,
    PWR_ON,
    PWR_RET,
    PWR_RET_EXIT,
    PWR_DOWN
  } pad_pwr_state_e;

  // The reserved bit never holds a 1, so reads of it are always 0.
  function automatic pad_cfg_t sanitize_cfg(input logic [7:0] wdata);
    return pad_cfg_t'(wdata & PAD_CFG_WMASK);
  endfunction

endpackage

// File: rtl/pad_alsaqr_in_filter.sv
// Per-pad input path: 2-flop synchroniser followed by an optional deglitcher
// that accepts a new level only after it has been stable for 2**FILT_W-1 cycles.
module pad_alsaqr_in_filter #(
  parameter int FILT_W = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic filt_en_i,
  input  logic pad_i,
  output logic filt_o
);

  // Last count value before the FILT_MAX-th consecutive mismatch.
  localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'((2 ** FILT_W) - 2);

  logic              sync1_q;
  logic              sync2_q;
  logic              filt_q;
  logic [FILT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
      if (!filt_en_i) begin
        filt_q <= sync2_q;
        cnt_q  <= '0;
      end else if (sync2_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        filt_q <= sync2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // With filtering off the synchroniser output goes straight through.
  assign filt_o = filt_en_i ? filt_q : sync2_q;

endmodule

// File: rtl/pad_alsaqr_bank_ctrl.sv
// Controller for a bank of pad_alsaqr IO cells: config register file,
// IO/core power and retention sequencer, pad output muxing and input filtering.
module pad_alsaqr_bank_ctrl
  import pad_alsaqr_pkg::*;
#(
  parameter  int NUM_PADS = 32,
  parameter  int FILT_W   = 4,
  parameter  int SEQ_DLY  = 16,
  localparam int AW       = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cfg_req_i,
  input  logic                  cfg_we_i,
  input  logic [AW-1:0]         cfg_addr_i,
  input  logic [7:0]            cfg_wdata_i,
  output logic                  cfg_gnt_o,
  output logic                  cfg_rvalid_o,
  output logic [7:0]            cfg_rdata_o,
  input  logic                  pwr_on_i,
  input  logic                  ret_en_i,
  output logic                  pwr_ready_o,
  input  logic [NUM_PADS-1:0]   core_oen_i,
  input  logic [NUM_PADS-1:0]   core_out_i,
  output logic [NUM_PADS-1:0]   core_in_o,
  output logic [NUM_PADS-1:0]   pad_oen_o,
  output logic [NUM_PADS-1:0]   pad_i_o,
  input  logic [NUM_PADS-1:0]   pad_o_i,
  output logic [2*NUM_PADS-1:0] pad_drv_o,
  output logic [NUM_PADS-1:0]   pad_puen_o,
  output logic [NUM_PADS-1:0]   pad_slw_o,
  output logic [NUM_PADS-1:0]   pad_smt_o,
  output logic                  iopwrok_o,
  output logic                  pwrok_o,
  output logic                  retc_o
);

  localparam int            CW        = $clog2(SEQ_DLY);
  localparam logic [CW-1:0] STEP_LAST = CW'(SEQ_DLY - 1);

  // ---------------- config register file ----------------
  // Handshake: a request is accepted in the cycle cfg_req_i is high
  // (cfg_gnt_o mirrors it); a read returns cfg_rvalid_o/cfg_rdata_o exactly
  // one cycle later with no back-pressure, a write lands on the same edge.
  pad_cfg_t              cfg_q [NUM_PADS];
  pad_cfg_t              rd_cfg;
  logic [NUM_PADS-1:0]   reg_hiz, reg_puen, reg_slw, reg_smt, reg_filt;
  logic [2*NUM_PADS-1:0] reg_drv;

  assign cfg_gnt_o = cfg_req_i;

  always_comb begin
    rd_cfg = '0;
    for (int n = 0; n < NUM_PADS; n++) begin
      if (cfg_addr_i == AW'(n)) rd_cfg = cfg_q[n];
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_PADS; n++) begin
      reg_drv[2*n +: 2] = cfg_q[n].drv;
      reg_puen[n]       = cfg_q[n].puen;
      reg_slw[n]        = cfg_q[n].slw;
      reg_smt[n]        = cfg_q[n].smt;
      reg_filt[n]       = cfg_q[n].filt_en;
      reg_hiz[n]        = cfg_q[n].force_hiz;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int n = 0; n < NUM_PADS; n++) cfg_q[n] <= PAD_CFG_RST;
    end else if (cfg_req_i && cfg_we_i) begin
      for (int n = 0; n < NUM_PADS; n++) begin
        if (cfg_addr_i == AW'(n)) cfg_q[n] <= sanitize_cfg(cfg_wdata_i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_rvalid_o <= 1'b0;
      cfg_rdata_o  <= 8'h00;
    end else begin
      cfg_rvalid_o <= cfg_req_i && !cfg_we_i;
      if (cfg_req_i && !cfg_we_i) cfg_rdata_o <= rd_cfg;
    end
  end

  // ---------------- power / retention sequencer ----------------
  pad_pwr_state_e state_q;
  logic [CW-1:0]  step_q;
  logic           step_done;

  assign step_done = (step_q == STEP_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= PWR_OFF;
      step_q      <= '0;
      iopwrok_o   <= 1'b0;
      pwrok_o     <= 1'b0;
      retc_o      <= 1'b0;
      pwr_ready_o <= 1'b0;
    end else if (!pwr_on_i && state_q != PWR_OFF && state_q != PWR_DOWN) begin
      // Power-off request wins over everything, including retention.
      state_q     <= PWR_DOWN;
      step_q      <= '0;
      pwrok_o     <= 1'b0;
      retc_o      <= 1'b0;
      pwr_ready_o <= 1'b0;
    end else begin
      case (state_q)
        PWR_OFF: begin
          if (pwr_on_i) begin
            state_q   <= PWR_IO_UP;
            step_q    <= '0;
            iopwrok_o <= 1'b1;
          end
        end
        PWR_IO_UP: begin
          if (step_done) begin
            state_q <= PWR_CORE_UP;
            step_q  <= '0;
            pwrok_o <= 1'b1;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        PWR_CORE_UP: begin
          if (step_done) begin
            state_q     <= PWR_ON;
            step_q      <= '0;
            pwr_ready_o <= 1'b1;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        PWR_ON: begin
          if (ret_en_i) begin
            state_q     <= PWR_RET;
            step_q      <= '0;
            retc_o      <= 1'b1;
            pwr_ready_o <= 1'b0;
          end
        end
        PWR_RET: begin
          if (!ret_en_i) begin
            state_q <= PWR_RET_EXIT;
            step_q  <= '0;
          end
        end
        PWR_RET_EXIT: begin
          if (step_done) begin
            state_q     <= PWR_ON;
            step_q      <= '0;
            retc_o      <= 1'b0;
            pwr_ready_o <= 1'b1;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        PWR_DOWN: begin
          if (step_done) begin
            state_q   <= PWR_OFF;
            step_q    <= '0;
            iopwrok_o <= 1'b0;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        default: begin
          state_q <= PWR_OFF;
          step_q  <= '0;
        end
      endcase
    end
  end

  // ---------------- retention freeze ----------------
  logic                  ret_entry;
  logic [NUM_PADS-1:0]   frz_oen_q, frz_i_q, frz_puen_q, frz_slw_q, frz_smt_q;
  logic [2*NUM_PADS-1:0] frz_drv_q;

  assign ret_entry = (state_q == PWR_ON) && pwr_on_i && ret_en_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frz_oen_q  <= '1;
      frz_i_q    <= '0;
      frz_drv_q  <= {NUM_PADS{PAD_CFG_RST.drv}};
      frz_puen_q <= {NUM_PADS{PAD_CFG_RST.puen}};
      frz_slw_q  <= {NUM_PADS{PAD_CFG_RST.slw}};
      frz_smt_q  <= {NUM_PADS{PAD_CFG_RST.smt}};
    end else if (ret_entry) begin
      frz_oen_q  <= core_oen_i | reg_hiz;
      frz_i_q    <= core_out_i;
      frz_drv_q  <= reg_drv;
      frz_puen_q <= reg_puen;
      frz_slw_q  <= reg_slw;
      frz_smt_q  <= reg_smt;
    end
  end

  // ---------------- pad output muxing ----------------
  always_comb begin
    pad_oen_o  = '1;
    pad_i_o    = '0;
    pad_drv_o  = reg_drv;
    pad_puen_o = reg_puen;
    pad_slw_o  = reg_slw;
    pad_smt_o  = reg_smt;
    case (state_q)
      PWR_ON: begin
        pad_oen_o = core_oen_i | reg_hiz;
        pad_i_o   = core_out_i;
      end
      PWR_RET, PWR_RET_EXIT: begin
        pad_oen_o  = frz_oen_q;
        pad_i_o    = frz_i_q;
        pad_drv_o  = frz_drv_q;
        pad_puen_o = frz_puen_q;
        pad_slw_o  = frz_slw_q;
        pad_smt_o  = frz_smt_q;
      end
      default: ;
    endcase
  end

  // ---------------- input path ----------------
  logic [NUM_PADS-1:0] filt_val;

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_in
    pad_alsaqr_in_filter #(
      .FILT_W (FILT_W)
    ) u_filt (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .filt_en_i (reg_filt[g]),
      .pad_i     (pad_o_i[g]),
      .filt_o    (filt_val[g])
    );
  end

  assign core_in_o = (state_q == PWR_ON) ? filt_val : '0;

endmodule

// File: tb/tb_pad_alsaqr_bank_ctrl.sv
// Self-checking bench for pad_alsaqr_bank_ctrl: randomized config traffic and
// pad stimulus against a behavioural model of the bank's published rules.
module tb_pad_alsaqr_bank_ctrl;

  localparam int NP = 24;
  localparam int FW = 4;
  localparam int SD = 16;
  localparam int AW = 5;
  localparam int PW = 7 * NP;

  logic          clk;
  logic          rst_n;
  logic          cfg_req, cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [7:0]    cfg_wdata;
  logic          cfg_gnt, cfg_rvalid;
  logic [7:0]    cfg_rdata;
  logic          pwr_on, ret_en, pwr_ready;
  logic [NP-1:0] core_oen, core_out, core_in;
  logic [NP-1:0] pad_oen, pad_i, pad_o, pad_puen, pad_slw, pad_smt;
  logic [2*NP-1:0] pad_drv;
  logic          iopwrok, pwrok, retc;

  pad_alsaqr_bank_ctrl #(
    .NUM_PADS (NP),
    .FILT_W   (FW),
    .SEQ_DLY  (SD)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cfg_req_i    (cfg_req),
    .cfg_we_i     (cfg_we),
    .cfg_addr_i   (cfg_addr),
    .cfg_wdata_i  (cfg_wdata),
    .cfg_gnt_o    (cfg_gnt),
    .cfg_rvalid_o (cfg_rvalid),
    .cfg_rdata_o  (cfg_rdata),
    .pwr_on_i     (pwr_on),
    .ret_en_i     (ret_en),
    .pwr_ready_o  (pwr_ready),
    .core_oen_i   (core_oen),
    .core_out_i   (core_out),
    .core_in_o    (core_in),
    .pad_oen_o    (pad_oen),
    .pad_i_o      (pad_i),
    .pad_o_i      (pad_o),
    .pad_drv_o    (pad_drv),
    .pad_puen_o   (pad_puen),
    .pad_slw_o    (pad_slw),
    .pad_smt_o    (pad_smt),
    .iopwrok_o    (iopwrok),
    .pwrok_o      (pwrok),
    .retc_o       (retc)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- model state and scoreboard ----------------
  logic [7:0] mdl_cfg [NP];
  logic [7:0] exp_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;

  function automatic logic [PW-1:0] exp_pads(input logic live, input logic [NP-1:0] coen,
                                             input logic [NP-1:0] cout);
    logic [NP-1:0]   oen, pi, pu, sl, sm;
    logic [2*NP-1:0] dr;
    for (int n = 0; n < NP; n++) begin
      dr[2*n +: 2] = mdl_cfg[n][1:0];
      pu[n]  = mdl_cfg[n][2];
      sl[n]  = mdl_cfg[n][3];
      sm[n]  = mdl_cfg[n][4];
      oen[n] = live ? (coen[n] | mdl_cfg[n][6]) : 1'b1;
      pi[n]  = live ? cout[n] : 1'b0;
    end
    return {oen, pi, dr, pu, sl, sm};
  endfunction

  function automatic logic [PW-1:0] obs_pads();
    return {pad_oen, pad_i, pad_drv, pad_puen, pad_slw, pad_smt};
  endfunction

  function automatic logic [7:0] mdl_read(input logic [AW-1:0] a);
    return (int'(a) < NP) ? mdl_cfg[a] : 8'h00;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [7:0] d);
    cfg_req   = 1'b1;
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_req = 1'b0;
    cfg_we  = 1'b0;
    if (int'(a) < NP) mdl_cfg[a] = d & 8'h7f;
  endtask

  task automatic model_reset();
    for (int n = 0; n < NP; n++) mdl_cfg[n] = 8'h55;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [AW-1:0] addrs [4];
    logic [7:0]    exp;
    addrs[0] = 5'd0; addrs[1] = 5'(NP - 1); addrs[2] = 5'(NP); addrs[3] = 5'd31;
    n_checks++;
    if ({iopwrok, pwrok, retc, pwr_ready, cfg_rvalid, cfg_rdata} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %h expected 000",
               {iopwrok, pwrok, retc, pwr_ready, cfg_rvalid, cfg_rdata});
    end
    n_checks++;
    if (obs_pads() !== exp_pads(1'b0, core_oen, core_out)) begin
      n_fail++;
      $display("FAIL reset_pads: got %h expected %h", obs_pads(), exp_pads(1'b0, core_oen, core_out));
    end
    n_checks++;
    if (core_in !== '0) begin
      n_fail++;
      $display("FAIL reset_core_in: got %h expected 0", core_in);
    end
    foreach (addrs[i]) begin
      cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = addrs[i];
      exp = mdl_read(addrs[i]);
      #1;
      n_checks++;
      if (cfg_gnt !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_gnt: got %b expected 1", cfg_gnt);
      end
      tick();
      cfg_req = 1'b0;
      n_checks++;
      if (cfg_rvalid !== 1'b1 || cfg_rdata !== exp) begin
        n_fail++;
        $display("FAIL reset_read addr %0d: got v=%b d=%h expected v=1 d=%h",
                 addrs[i], cfg_rvalid, cfg_rdata, exp);
      end
      tick();
      n_checks++;
      if (cfg_rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_rvalid_drop: got %b expected 0", cfg_rvalid);
      end
    end
  endtask

  task automatic test_cfg_bus();
    logic        was_read;
    logic [7:0]  exp;
    was_read = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cfg_req   = ($urandom_range(0, 3) != 0);
      cfg_we    = $urandom_range(0, 1);
      cfg_addr  = AW'($urandom_range(0, 31));
      cfg_wdata = 8'($urandom);
      #1;
      n_checks++;
      if (cfg_gnt !== cfg_req) begin
        n_fail++;
        $display("FAIL cfg_gnt: got %b expected %b", cfg_gnt, cfg_req);
      end
      if (cfg_req && !cfg_we) exp_q.push_back(mdl_read(cfg_addr));
      if (cfg_req && cfg_we && int'(cfg_addr) < NP) mdl_cfg[cfg_addr] = cfg_wdata & 8'h7f;
      was_read = cfg_req && !cfg_we;
      tick();
      n_checks++;
      if (cfg_rvalid !== was_read) begin
        n_fail++;
        $display("FAIL cfg_rvalid: got %b expected %b", cfg_rvalid, was_read);
      end
      if (was_read && exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (cfg_rdata !== exp) begin
          n_fail++;
          $display("FAIL cfg_rdata: got %h expected %h", cfg_rdata, exp);
        end
      end
    end
    cfg_req = 1'b0;
    cfg_we  = 1'b0;
    tick();
  endtask

  task automatic test_power_up();
    logic [3:0] exp;
    core_oen = NP'($urandom);
    core_out = NP'($urandom);
    pwr_on   = 1'b1;
    for (int t = 1; t <= 2 * SD + 1; t++) begin
      tick();
      exp = {1'b1, t >= 1 + SD, t >= 1 + 2 * SD, 1'b0};
      n_checks++;
      if ({iopwrok, pwrok, pwr_ready, retc} !== exp) begin
        n_fail++;
        $display("FAIL pwr_up t=%0d: got %b expected %b", t, {iopwrok, pwrok, pwr_ready, retc}, exp);
      end
      n_checks++;
      if (obs_pads() !== exp_pads(t >= 1 + 2 * SD, core_oen, core_out)) begin
        n_fail++;
        $display("FAIL pwr_up_pads t=%0d: got %h expected %h", t, obs_pads(),
                 exp_pads(t >= 1 + 2 * SD, core_oen, core_out));
      end
    end
  endtask

  task automatic test_pad_out();
    cfg_write(5'd3, 8'h00);
    core_oen[3] = 1'b0;
    core_out[3] = 1'b1;
    #1;
    n_checks++;
    if ({pad_oen[3], pad_i[3], pad_drv[7:6]} !== 4'b0100) begin
      n_fail++;
      $display("FAIL pad3_direct: got %b expected 0100", {pad_oen[3], pad_i[3], pad_drv[7:6]});
    end
    for (int i = 0; i < 12; i++) begin
      core_oen = NP'($urandom);
      core_out = NP'($urandom);
      cfg_write(AW'($urandom_range(0, NP - 1)), 8'($urandom) & 8'hdf);
      n_checks++;
      if (obs_pads() !== exp_pads(1'b1, core_oen, core_out)) begin
        n_fail++;
        $display("FAIL pad_out_rand %0d: got %h expected %h", i, obs_pads(),
                 exp_pads(1'b1, core_oen, core_out));
      end
    end
  endtask

  task automatic test_input_sync();
    logic [NP-1:0] mask, prev;
    for (int n = 0; n < NP; n++) mask[n] = ~mdl_cfg[n][5];
    prev = '0;
    for (int i = 0; i < 16; i++) begin
      pad_o = NP'($urandom);
      tick();
      if (i > 0) begin
        n_checks++;
        if ((core_in & mask) !== (prev & mask)) begin
          n_fail++;
          $display("FAIL input_sync %0d: got %h expected %h", i, core_in & mask, prev & mask);
        end
      end
      prev = pad_o;
    end
  endtask

  task automatic test_filter();
    logic exp;
    cfg_write(5'd5, 8'h20);
    pad_o = '0;
    repeat (20) tick();
    pad_o[5] = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (t == 10) pad_o[5] = 1'b0;
      n_checks++;
      if (core_in[5] !== 1'b0) begin
        n_fail++;
        $display("FAIL filt_short t=%0d: got %b expected 0", t, core_in[5]);
      end
    end
    pad_o[5] = 1'b1;
    for (int t = 1; t <= 45; t++) begin
      tick();
      if (t == 20) pad_o[5] = 1'b0;
      exp = (t >= 17) && (t < 37);
      n_checks++;
      if (core_in[5] !== exp) begin
        n_fail++;
        $display("FAIL filt_long t=%0d: got %b expected %b", t, core_in[5], exp);
      end
    end
  endtask

  task automatic test_retention();
    logic [PW-1:0] frz;
    logic [PW-1:0] exp;
    core_oen = NP'($urandom);
    core_out = NP'($urandom);
    pad_o    = '1;
    #1;
    frz    = exp_pads(1'b1, core_oen, core_out);
    ret_en = 1'b1;
    tick();
    n_checks++;
    if ({iopwrok, pwrok, retc, pwr_ready} !== 4'b1110) begin
      n_fail++;
      $display("FAIL ret_enter: got %b expected 1110", {iopwrok, pwrok, retc, pwr_ready});
    end
    for (int i = 0; i < 6; i++) begin
      core_oen = NP'($urandom);
      core_out = NP'($urandom);
      cfg_write(AW'($urandom_range(0, NP - 1)), 8'($urandom) & 8'hdf);
      n_checks++;
      if (obs_pads() !== frz || core_in !== '0) begin
        n_fail++;
        $display("FAIL ret_frozen %0d: got %h/%h expected %h/0", i, obs_pads(), core_in, frz);
      end
    end
    ret_en = 1'b0;
    for (int t = 1; t <= SD + 1; t++) begin
      tick();
      exp = (t >= 1 + SD) ? exp_pads(1'b1, core_oen, core_out) : frz;
      n_checks++;
      if ({retc, pwr_ready} !== {t < 1 + SD, t >= 1 + SD} || obs_pads() !== exp) begin
        n_fail++;
        $display("FAIL ret_exit t=%0d: got retc=%b rdy=%b pads=%h expected retc=%b rdy=%b pads=%h",
                 t, retc, pwr_ready, obs_pads(), t < 1 + SD, t >= 1 + SD, exp);
      end
    end
  endtask

  task automatic test_power_down();
    logic exp_io;
    ret_en = 1'b1;
    tick();
    n_checks++;
    if (retc !== 1'b1) begin
      n_fail++;
      $display("FAIL down_ret_enter: got %b expected 1", retc);
    end
    pwr_on = 1'b0;
    for (int t = 1; t <= SD + 3; t++) begin
      if (t == 6) pwr_on = 1'b1;
      tick();
      exp_io = (t < 1 + SD) || (t >= 2 + SD);
      n_checks++;
      if ({iopwrok, pwrok, retc, pwr_ready} !== {exp_io, 3'b000}) begin
        n_fail++;
        $display("FAIL pwr_down t=%0d: got %b expected %b", t,
                 {iopwrok, pwrok, retc, pwr_ready}, {exp_io, 3'b000});
      end
      n_checks++;
      if (obs_pads() !== exp_pads(1'b0, core_oen, core_out) || core_in !== '0) begin
        n_fail++;
        $display("FAIL pwr_down_pads t=%0d: got %h/%h expected %h/0", t, obs_pads(), core_in,
                 exp_pads(1'b0, core_oen, core_out));
      end
    end
    ret_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    repeat (3) tick();
    pad_o = '1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({iopwrok, pwrok, retc, pwr_ready, cfg_rvalid, cfg_rdata} !== 12'h000 || core_in !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_ctrl: got %h/%h expected 000/0",
               {iopwrok, pwrok, retc, pwr_ready, cfg_rvalid, cfg_rdata}, core_in);
    end
    n_checks++;
    if (obs_pads() !== exp_pads(1'b0, core_oen, core_out)) begin
      n_fail++;
      $display("FAIL reset_mid_pads: got %h expected %h", obs_pads(),
               exp_pads(1'b0, core_oen, core_out));
    end
    pwr_on = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 5'd3;
    tick();
    cfg_req = 1'b0;
    n_checks++;
    if (cfg_rvalid !== 1'b1 || cfg_rdata !== 8'h55 || iopwrok !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_read: got v=%b d=%h io=%b expected v=1 d=55 io=0",
               cfg_rvalid, cfg_rdata, iopwrok);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    pwr_on = 1'b0; ret_en = 1'b0;
    core_oen = '0; core_out = '0; pad_o = '1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_cfg_bus();
    test_power_up();
    test_pad_out();
    test_input_sync();
    test_filter();
    test_retention();
    test_power_down();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
